// File: rtl/ahb3lite_bus_arbiter.sv
// Round-robin AHB3-Lite arbiter with idle-timeout preemption; grants move only on IDLE+HREADY.
// Define ARB_FIXED_PRIORITY_EN to replace round-robin with lowest-index-first priority.
module ahb3lite_bus_arbiter #(
    parameter int NUM_MASTERS  = 4,
    parameter int IDLE_TIMEOUT = 8
) (
    input  logic                           HCLK,
    input  logic                           HRESET,
    input  logic [NUM_MASTERS-1:0]         i_HBUSREQ,
    input  logic [1:0]                     HTRANS,
    input  logic                           HREADY,
    output logic [NUM_MASTERS-1:0]         o_HGRANT,
    output logic [$clog2(NUM_MASTERS)-1:0] o_HMASTER,
    output logic [$clog2(NUM_MASTERS)-1:0] o_HMASTER_D,
    output logic                           o_arb_busy
);

    localparam int         IW      = $clog2(NUM_MASTERS);
    localparam logic [7:0] CNT_MAX = 8'(IDLE_TIMEOUT - 1);
    localparam logic [1:0] HT_IDLE = 2'b00;
    localparam logic [0:0] ST_PARK = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    logic [0:0]             r_state;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [IW-1:0]          r_hmaster;
    logic [IW-1:0]          r_hmaster_d;
    logic [7:0]             r_idle_cnt;
`ifndef ARB_FIXED_PRIORITY_EN
    logic [IW-1:0]          r_rr;
`endif

    logic                   w_idle;
    logic                   w_step;
    logic                   w_owner_req;
    logic                   w_others;
    logic                   w_cnt_sat;
    logic                   w_preempt;
    logic                   w_arb;
    logic [NUM_MASTERS-1:0] w_mask;
    logic                   w_found;
    logic [IW-1:0]          w_win;

    assign w_idle      = (HTRANS == HT_IDLE);
    assign w_step      = HREADY && w_idle;
    assign w_owner_req = i_HBUSREQ[r_hmaster];
    assign w_others    = |(i_HBUSREQ & ~r_grant);
    assign w_cnt_sat   = (r_idle_cnt == CNT_MAX);
    assign w_preempt   = (r_state == ST_OWN) && w_owner_req
                         && w_cnt_sat && w_others;
    assign w_arb       = w_step && ((r_state == ST_PARK)
                         || !w_owner_req || w_preempt);

    // A timed-out owner is removed from the candidate set
    assign w_mask = w_preempt ? (i_HBUSREQ & ~r_grant) : i_HBUSREQ;

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
`ifdef ARB_FIXED_PRIORITY_EN
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (w_mask[i]) begin
                w_found = 1'b1;
                w_win   = IW'(i);
            end
        end
`else
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!w_found && w_mask[(int'(r_rr) + i) % NUM_MASTERS]) begin
                w_found = 1'b1;
                w_win   = IW'((int'(r_rr) + i) % NUM_MASTERS);
            end
        end
`endif
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state     <= ST_PARK;
            r_grant     <= NUM_MASTERS'(1);
            r_hmaster   <= '0;
            r_hmaster_d <= '0;
            r_idle_cnt  <= '0;
`ifndef ARB_FIXED_PRIORITY_EN
            r_rr        <= '0;
`endif
        end else begin
            if (HREADY)
                r_hmaster_d <= r_hmaster;

            if (w_arb) begin
                if (w_found) begin
                    r_state   <= ST_OWN;
                    r_grant   <= NUM_MASTERS'(1) << w_win;
                    r_hmaster <= w_win;
`ifndef ARB_FIXED_PRIORITY_EN
                    r_rr      <= (int'(w_win) == NUM_MASTERS - 1)
                                 ? '0 : w_win + 1'b1;
`endif
                end else begin
                    r_state   <= ST_PARK;
                    r_grant   <= NUM_MASTERS'(1);
                    r_hmaster <= '0;
                end
            end

            // Saturation with no rival means the sole owner restarts its window
            if (w_arb)
                r_idle_cnt <= '0;
            else if (!HREADY)
                r_idle_cnt <= r_idle_cnt;
            else if (!w_idle || (r_state == ST_PARK) || w_cnt_sat)
                r_idle_cnt <= '0;
            else
                r_idle_cnt <= r_idle_cnt + 8'd1;
        end
    end

    assign o_HGRANT    = r_grant;
    assign o_HMASTER   = r_hmaster;
    assign o_HMASTER_D = r_hmaster_d;
    assign o_arb_busy  = !w_idle;

endmodule

// File: tb/tb_ahb3lite_bus_arbiter.sv
// Directed-vector scoreboard bench for ahb3lite_bus_arbiter (4 masters, timeout 8).
module tb_ahb3lite_bus_arbiter;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] BUSY = 2'b01;
    localparam logic [1:0] NSEQ = 2'b10;
    localparam logic [1:0] SEQ  = 2'b11;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] hmd;
        logic       busy;
    } exp_t;

    logic       HCLK = 1'b0;
    logic       HRESET;
    logic [3:0] req;
    logic [1:0] htrans;
    logic       hready;
    logic [3:0] o_HGRANT;
    logic [1:0] o_HMASTER;
    logic [1:0] o_HMASTER_D;
    logic       o_arb_busy;

    exp_t  q[$];
    string qn[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    ahb3lite_bus_arbiter #(
        .NUM_MASTERS (4),
        .IDLE_TIMEOUT(8)
    ) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .i_HBUSREQ  (req),
        .HTRANS     (htrans),
        .HREADY     (hready),
        .o_HGRANT   (o_HGRANT),
        .o_HMASTER  (o_HMASTER),
        .o_HMASTER_D(o_HMASTER_D),
        .o_arb_busy (o_arb_busy)
    );

    always #5 HCLK = ~HCLK;

    function automatic logic [1:0] idx(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++)
            if (g[i]) r = 2'(i);
        return r;
    endfunction

    // Monitor: every sampled cycle with a queued expectation is checked
    always @(negedge HCLK) begin
        exp_t  e;
        string nm;
        if (q.size() > 0) begin
            e  = q.pop_front();
            nm = qn.pop_front();
            n_cmp++;
            if (o_HGRANT !== e.g || o_HMASTER !== idx(e.g) ||
                o_HMASTER_D !== e.hmd || o_arb_busy !== e.busy) begin
                n_bad++;
                $display("FAIL %s: got grant=%b hm=%0d hmd=%0d busy=%b want grant=%b hm=%0d hmd=%0d busy=%b",
                         nm, o_HGRANT, o_HMASTER, o_HMASTER_D, o_arb_busy,
                         e.g, idx(e.g), e.hmd, e.busy);
            end
        end
    end

    task automatic step(input logic [3:0] r, input logic [1:0] t,
                        input logic rdy, input logic [3:0] g,
                        input logic [1:0] hmd, input string nm);
        exp_t e;
        req    = r;
        htrans = t;
        hready = rdy;
        e.g    = g;
        e.hmd  = hmd;
        e.busy = (t != IDLE);
        q.push_back(e);
        qn.push_back(nm);
        @(posedge HCLK);
        @(negedge HCLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        HRESET = 1'b1;
        step(4'b0000, IDLE, 1, 4'b0001, 2'd0, "reset");
        HRESET = 1'b0;
        for (int i = 0; i < 20; i++)
            step(4'b0000, IDLE, 1, 4'b0001, 2'd0, "park_hold");

        // masters 1 and 3 together, rr at 0
        step(4'b1010, IDLE, 1, 4'b0010, 2'd0, "s2_grant1");
        step(4'b1010, NSEQ, 1, 4'b0010, 2'd1, "s2_nseq");
        for (int i = 0; i < 3; i++)
            step(4'b1010, SEQ, 1, 4'b0010, 2'd1, "s2_seq");
        step(4'b1000, IDLE, 1, 4'b1000, 2'd1, "s2_grant3");
        step(4'b1000, NSEQ, 1, 4'b1000, 2'd3, "s2_m3_xfer");
        step(4'b0000, IDLE, 1, 4'b0001, 2'd3, "s2_park");
        step(4'b0000, IDLE, 1, 4'b0001, 2'd0, "s2_parked");

        // master 2 INCR8 with wait states while master 0 requests
        step(4'b0100, IDLE, 1, 4'b0100, 2'd0, "s3_grant2");
        step(4'b0101, NSEQ, 1, 4'b0100, 2'd2, "s3_nseq");
        step(4'b0101, SEQ,  1, 4'b0100, 2'd2, "s3_seq");
        for (int i = 0; i < 3; i++)
            step(4'b0101, SEQ, 0, 4'b0100, 2'd2, "s3_wait");
        for (int i = 0; i < 6; i++)
            step(4'b0101, SEQ, 1, 4'b0100, 2'd2, "s3_seq_tail");
        step(4'b0001, IDLE, 0, 4'b0100, 2'd2, "s3_idle_wait");
        step(4'b0001, IDLE, 1, 4'b0001, 2'd2, "s3_grant0");
        step(4'b0001, NSEQ, 1, 4'b0001, 2'd0, "s3_m0_xfer");
        step(4'b0000, IDLE, 1, 4'b0001, 2'd0, "s3_park");

        // idle timeout preemption of master 1 by master 2
        step(4'b0110, IDLE, 1, 4'b0010, 2'd0, "s4_grant1");
        for (int i = 0; i < 7; i++)
            step(4'b0110, IDLE, 1, 4'b0010, 2'd1, "s4_idle");
        step(4'b0110, IDLE, 1, 4'b0100, 2'd1, "s4_preempt");
        step(4'b0110, IDLE, 1, 4'b0100, 2'd2, "s4_new_owner");
        step(4'b0010, IDLE, 1, 4'b0010, 2'd2, "s4_back1");
        step(4'b0000, IDLE, 1, 4'b0001, 2'd1, "s4_park");

        // owner drops request mid-burst
        step(4'b1000, IDLE, 1, 4'b1000, 2'd0, "s5_grant3");
        step(4'b1000, NSEQ, 1, 4'b1000, 2'd3, "s5_nseq");
        step(4'b0001, SEQ,  1, 4'b1000, 2'd3, "s5_drop_seq");
        step(4'b0001, SEQ,  1, 4'b1000, 2'd3, "s5_seq");
        step(4'b0001, BUSY, 1, 4'b1000, 2'd3, "s5_busy");
        step(4'b0001, IDLE, 1, 4'b0001, 2'd3, "s5_grant0");
        step(4'b0000, IDLE, 1, 4'b0001, 2'd0, "s5_park");

`ifdef ARB_FIXED_PRIORITY_EN
        step(4'b1001, IDLE, 1, 4'b0001, 2'd0, "s6_grant0");
        step(4'b1001, NSEQ, 1, 4'b0001, 2'd0, "s6_m0");
        for (int i = 0; i < 7; i++)
            step(4'b1001, IDLE, 1, 4'b0001, 2'd0, "s6_hold0");
        step(4'b1001, IDLE, 1, 4'b1000, 2'd0, "s6_preempt3");
        step(4'b1001, NSEQ, 1, 4'b1000, 2'd3, "s6_m3");
        step(4'b0001, IDLE, 1, 4'b0001, 2'd3, "s6_back0");
        step(4'b0000, IDLE, 1, 4'b0001, 2'd0, "s6_park");
`else
        // rr pointer sits at 1 here, so 3 wins first
        step(4'b1001, IDLE, 1, 4'b1000, 2'd0, "s6_grant3");
        step(4'b1001, NSEQ, 1, 4'b1000, 2'd3, "s6_m3");
        step(4'b0001, IDLE, 1, 4'b0001, 2'd3, "s6_alt0");
        step(4'b1001, NSEQ, 1, 4'b0001, 2'd0, "s6_m0");
        step(4'b1000, IDLE, 1, 4'b1000, 2'd0, "s6_alt3");
        step(4'b1001, NSEQ, 1, 4'b1000, 2'd3, "s6_m3b");
        step(4'b0001, IDLE, 1, 4'b0001, 2'd3, "s6_alt0b");
        step(4'b0000, IDLE, 1, 4'b0001, 2'd0, "s6_park");
`endif

        // reset in the middle of a burst
        step(4'b0100, IDLE, 1, 4'b0100, 2'd0, "s7_grant2");
        step(4'b0100, NSEQ, 1, 4'b0100, 2'd2, "s7_nseq");
        HRESET = 1'b1;
        step(4'b0100, SEQ,  1, 4'b0001, 2'd0, "s7_reset_mid");
        HRESET = 1'b0;
        step(4'b0000, IDLE, 1, 4'b0001, 2'd0, "s7_after");

        for (int k = 0; k < 5 && q.size() != 0; k++)
            @(negedge HCLK);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
